gp9001_host_bridge: RTL and testbench
=====================================

# gp9001_host_bridge

Parametrised 68000-to-GP9001 host bridge for Toaplan2 boards with one or more VDPs (single-VDP titles: `NCH=1`; Batsugun/Dogyuun class: `NCH=2`). It sits between the per-game CPU address decoder and the GP9001 op-strobe interface, and does four things:
- turns CPU accesses into held op strobes and holds them until the VDP acknowledges;
- returns read data and the VBLANK status word;
- drives `BUSY` into the DTACK generator;
- recovers from a missing ACK with a watchdog, which the single-VDP glue lacks.

## Interface
Parameters:
- `NCH`, 2, number of GP9001 channels (1..4)
- `DW`, 16, data width
- `TOW`, 8, watchdog counter width
- `TIMEOUT`, 200, CLK96 cycles allowed in WAIT_ACK before abort (< 2^TOW)

Ports:
- `CLK96` in 1: single clock. Reset is asynchronous and active-low: `RESET96n` in 1.
- `CS` in NCH: per-VDP select from the address decoder, held for the whole bus cycle.
- `RW` in 1: 1 = read.
- `A` in 3: CPU address bits [3:1].
- `DSn` in 2: {UDSn, LDSn}.
- `DIN` in DW: CPU write data.
- `DOUT` out DW: read data to the CPU mux.
- `BUSY` out 1: request is pending; feeds `bus_busy`.
- `OP_SET_RAM_PTR`, `OP_WRITE_RAM`, `OP_SELECT_REG`, `OP_WRITE_REG`, `OP_READ_RAM_H`, `OP_READ_RAM_L` out NCH each: one-hot op strobes, bit per channel.
- `OP_DATA` out DW: latched write data to the VDPs.
- `VDP_ACK` in NCH: per-channel op acknowledge.
- `VDP_DOUT` in NCH*DW: per-channel read data; channel k is at [k*DW +: DW].
- `VBLANK` in NCH: per-channel vertical blank, active high.
- `TO_FLAG` out NCH: sticky per-channel timeout flag.
- `TO_CLR` in 1: clears all bits of `TO_FLAG`.

## Operation
Offset decode uses {A,0}:
- Writes: 0x0 → SET_RAM_PTR; 0x4 or 0x6 → WRITE_RAM; 0x8 → SELECT_REG; 0xC → WRITE_REG. Any other write offset completes without an op.
- Reads: 0x4 → READ_RAM_H; 0x6 → READ_RAM_L.
- Read 0xC → status word {15'b0, ~VBLANK[ch]}. It issues no op and completes immediately.
- Other read offsets return 0x0000 and issue no op.
- A write with DSn = 2'b11 completes without an op.

Channel selection: the lowest set bit of `CS` is serviced. Decode normally guarantees one-hot; any higher bits set at the same time are ignored for that access.

States:
- IDLE: if any CS bit is set, latch ch, offset, RW and DIN into `OP_DATA`. For an op access go to ISSUE; for a no-op access go to DONE with `DOUT` loaded.
- ISSUE: raise the one op strobe for ch. Clear the watchdog. Go to WAIT_ACK.
- WAIT_ACK: hold the strobe.
  - When `VDP_ACK[ch]` = 1: drop the strobe. For reads, capture `VDP_DOUT[ch]` into `DOUT`. Go to DONE.
  - When the watchdog reaches TIMEOUT: drop the strobe, set `DOUT` = 0xFFFF, set `TO_FLAG[ch]`, go to DONE.
- DONE: `BUSY` = 0. Stay until `CS[ch]` = 0, then go to IDLE. This gives exactly one op per CPU bus cycle.

`BUSY` = (|CS) & (state ≠ DONE) & ~(state == IDLE & no-op decode). The no-op term is combinational so that no-op accesses never stall.

If `CS[ch]` drops during ISSUE or WAIT_ACK (aborted cycle), the op still runs until ACK or timeout, then the FSM goes straight to IDLE. Its result is discarded.

`TO_CLR` and a new timeout on the same cycle: the set wins for that channel.

`OP_DATA` and `DOUT` hold their values until the next latch event.

## Timing
- Reset values: all strobes 0, `BUSY` 0, `DOUT` 0x0000, `OP_DATA` 0x0000, `TO_FLAG` 0, state IDLE, watchdog 0.
- Op latency:
  - CS seen in IDLE at edge 0; strobe high from edge 1.
  - ACK sampled high at edge n; strobe low and `DOUT` valid after edge n, `BUSY` low after edge n.
  - Minimum CS-to-`BUSY`-low is 2 cycles.
- No-op and status reads: `DOUT` valid after edge 0, and `BUSY` is never asserted.
- Watchdog: counts every cycle in WAIT_ACK and aborts on the cycle it equals TIMEOUT. The strobe is high for exactly TIMEOUT+1 cycles. Counter width is `TOW` and it never wraps.
- ACK held high by the VDP after completion is ignored outside WAIT_ACK.

## Structure
- Shared package `toaplan2_pkg`:
  - op enum (`OP_NONE`, `OP_PTR`, `OP_WRAM`, `OP_SEL`, `OP_WREG`, `OP_RDH`, `OP_RDL`);
  - offset constants 0x0/0x4/0x6/0x8/0xC;
  - FSM state enum.
- One sub-module, `gp9001_op_decode`: combinational {RW, offset, DSn} → op enum plus the no-op and status flags.
- The lowest-bit channel encoder stays inline.

## Test plan
- NCH=2, write 0x1234 at 0x8 on ch1, ACK after 3 cycles → `OP_SELECT_REG` = 2'b10 for 4 cycles, `OP_DATA` = 0x1234, `BUSY` released one cycle after the ACK.
- Read 0x4 on ch0 with `VDP_DOUT[0]` = 0xBEEF, ACK after 1 cycle → `OP_READ_RAM_H[0]` pulse, `DOUT` = 0xBEEF, no strobe on ch1.
- Read 0xC with `VBLANK` = 2'b01: on ch0 → `DOUT` = 0x0000; on ch1 → `DOUT` = 0x0001; `BUSY` never high.
- TIMEOUT=10, no ACK on ch1 → strobe high for 11 cycles, `DOUT` = 0xFFFF, `TO_FLAG` = 2'b10; `TO_CLR` → 2'b00; a timeout coinciding with `TO_CLR` leaves the flag set.
- CS held for 20 cycles with ACK held high → exactly one strobe pulse. CS = 2'b11 → only ch0 is serviced.
- `RESET96n` low during WAIT_ACK → strobes, `BUSY` and `DOUT` return to reset values asynchronously; the next access after release completes normally.

Source files
------------

// File: rtl/toaplan2_pkg.sv
// Shared Toaplan2 definitions: GP9001 op codes, host register offsets and
// the host bridge FSM state encoding.
package toaplan2_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_PTR  = 3'd1,
    OP_WRAM = 3'd2,
    OP_SEL  = 3'd3,
    OP_WREG = 3'd4,
    OP_RDH  = 3'd5,
    OP_RDL  = 3'd6
  } op_e;

  // Byte offsets ({A,0}) of the GP9001 host window
  localparam logic [3:0] OFS_PTR   = 4'h0;
  localparam logic [3:0] OFS_RAM_H = 4'h4;
  localparam logic [3:0] OFS_RAM_L = 4'h6;
  localparam logic [3:0] OFS_SEL   = 4'h8;
  localparam logic [3:0] OFS_REG   = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/gp9001_op_decode.sv
// Combinational decode of a CPU access ({RW, offset, DSn}) into a GP9001 op.
// noop marks accesses that complete without touching the VDP; status marks
// the VBLANK status read.
module gp9001_op_decode
  import toaplan2_pkg::*;
(
  input  logic       rw,
  input  logic [3:0] ofs,
  input  logic [1:0] dsn,
  output op_e        op,
  output logic       noop,
  output logic       status
);

  // Offset/direction to op mapping; writes with no data strobe do nothing
  always_comb begin
    op     = OP_NONE;
    status = 1'b0;
    if (rw) begin
      case (ofs)
        OFS_RAM_H: op = OP_RDH;
        OFS_RAM_L: op = OP_RDL;
        OFS_REG:   status = 1'b1;
        default:   op = OP_NONE;
      endcase
    end else if (dsn == 2'b11) begin
      op = OP_NONE;
    end else begin
      case (ofs)
        OFS_PTR:   op = OP_PTR;
        OFS_RAM_H: op = OP_WRAM;
        OFS_RAM_L: op = OP_WRAM;
        OFS_SEL:   op = OP_SEL;
        OFS_REG:   op = OP_WREG;
        default:   op = OP_NONE;
      endcase
    end
  end

  assign noop = (op == OP_NONE);

endmodule

// File: rtl/gp9001_host_bridge.sv
// 68000 to GP9001 host bridge: turns CPU bus cycles into held op strobes on
// one of NCH VDP channels, returns read/status data, drives BUSY for DTACK,
// and aborts a stuck op with a watchdog that flags the offending channel.
module gp9001_host_bridge
  import toaplan2_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DW      = 16,
  parameter int TOW     = 8,
  parameter int TIMEOUT = 200
) (
  input  logic              CLK96,
  input  logic              RESET96n,
  input  logic [NCH-1:0]    CS,
  input  logic              RW,
  input  logic [2:0]        A,
  input  logic [1:0]        DSn,
  input  logic [DW-1:0]     DIN,
  output logic [DW-1:0]     DOUT,
  output logic              BUSY,
  output logic [NCH-1:0]    OP_SET_RAM_PTR,
  output logic [NCH-1:0]    OP_WRITE_RAM,
  output logic [NCH-1:0]    OP_SELECT_REG,
  output logic [NCH-1:0]    OP_WRITE_REG,
  output logic [NCH-1:0]    OP_READ_RAM_H,
  output logic [NCH-1:0]    OP_READ_RAM_L,
  output logic [DW-1:0]     OP_DATA,
  input  logic [NCH-1:0]    VDP_ACK,
  input  logic [NCH*DW-1:0] VDP_DOUT,
  input  logic [NCH-1:0]    VBLANK,
  output logic [NCH-1:0]    TO_FLAG,
  input  logic              TO_CLR
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [3:0]     ofs_s;
  op_e            dec_op_s;
  logic           dec_noop_s;
  logic           dec_status_s;
  logic           cs_any_s;
  logic [CW-1:0]  cs_ch_s;
  logic [NCH-1:0] ch_oh_s;
  logic [DW-1:0]  vdp_sel_s;
  logic           cs_cur_s;
  logic           is_rd_s;

  state_e         state_r;
  logic [CW-1:0]  ch_r;
  op_e            op_r;
  logic           cs_lost_r;
  logic [TOW-1:0] wd_r;
  logic [DW-1:0]  dout_r;
  logic [DW-1:0]  op_data_r;
  logic [NCH-1:0] to_flag_r;
  logic [NCH-1:0] ptr_r, wram_r, sel_r, wreg_r, rdh_r, rdl_r;

  assign ofs_s = {A, 1'b0};

  gp9001_op_decode u_dec (
    .rw     (RW),
    .ofs    (ofs_s),
    .dsn    (DSn),
    .op     (dec_op_s),
    .noop   (dec_noop_s),
    .status (dec_status_s)
  );

  assign cs_any_s = |CS;

  // Lowest set CS bit wins; higher simultaneous selects are ignored
  always_comb begin
    cs_ch_s = {CW{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      if (CS[i]) begin
        cs_ch_s = CW'(i);
      end else begin
        cs_ch_s = cs_ch_s;
      end
    end
  end

  // One-hot form of the latched channel, used to place strobes and flags
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_oh_s[i] = (ch_r == CW'(i));
    end
  end

  // Read data and select of the latched channel
  always_comb begin
    vdp_sel_s = VDP_DOUT[int'(ch_r) * DW +: DW];
    cs_cur_s  = CS[ch_r];
    is_rd_s   = (op_r == OP_RDH) || (op_r == OP_RDL);
  end

  // Bridge FSM with registered strobes, read data, write data and timeout flags
  always_ff @(posedge CLK96 or negedge RESET96n) begin
    if (!RESET96n) begin
      state_r   <= ST_IDLE;
      ch_r      <= {CW{1'b0}};
      op_r      <= OP_NONE;
      cs_lost_r <= 1'b0;
      wd_r      <= {TOW{1'b0}};
      dout_r    <= {DW{1'b0}};
      op_data_r <= {DW{1'b0}};
      to_flag_r <= {NCH{1'b0}};
      ptr_r     <= {NCH{1'b0}};
      wram_r    <= {NCH{1'b0}};
      sel_r     <= {NCH{1'b0}};
      wreg_r    <= {NCH{1'b0}};
      rdh_r     <= {NCH{1'b0}};
      rdl_r     <= {NCH{1'b0}};
    end else begin
      to_flag_r <= to_flag_r & ~{NCH{TO_CLR}};
      case (state_r)
        ST_IDLE: begin
          if (cs_any_s) begin
            ch_r      <= cs_ch_s;
            op_r      <= dec_op_s;
            op_data_r <= DIN;
            cs_lost_r <= 1'b0;
            if (dec_noop_s) begin
              dout_r  <= dec_status_s ? {{(DW-1){1'b0}}, ~VBLANK[cs_ch_s]} : {DW{1'b0}};
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          ptr_r   <= (op_r == OP_PTR)  ? ch_oh_s : {NCH{1'b0}};
          wram_r  <= (op_r == OP_WRAM) ? ch_oh_s : {NCH{1'b0}};
          sel_r   <= (op_r == OP_SEL)  ? ch_oh_s : {NCH{1'b0}};
          wreg_r  <= (op_r == OP_WREG) ? ch_oh_s : {NCH{1'b0}};
          rdh_r   <= (op_r == OP_RDH)  ? ch_oh_s : {NCH{1'b0}};
          rdl_r   <= (op_r == OP_RDL)  ? ch_oh_s : {NCH{1'b0}};
          wd_r    <= {TOW{1'b0}};
          state_r <= ST_WAIT_ACK;
          if (!cs_cur_s) begin
            cs_lost_r <= 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (VDP_ACK[ch_r] || (wd_r == TOW'(TIMEOUT))) begin
            ptr_r  <= {NCH{1'b0}};
            wram_r <= {NCH{1'b0}};
            sel_r  <= {NCH{1'b0}};
            wreg_r <= {NCH{1'b0}};
            rdh_r  <= {NCH{1'b0}};
            rdl_r  <= {NCH{1'b0}};
            // An aborted CPU cycle still finishes the op but drops its result
            if (cs_lost_r || !cs_cur_s) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_DONE;
              if (!VDP_ACK[ch_r]) begin
                dout_r <= {DW{1'b1}};
              end else if (is_rd_s) begin
                dout_r <= vdp_sel_s;
              end
            end
            // A new timeout overrides a simultaneous clear on its channel
            if (!VDP_ACK[ch_r]) begin
              to_flag_r <= (to_flag_r & ~{NCH{TO_CLR}}) | ch_oh_s;
            end
          end else begin
            wd_r <= wd_r + TOW'(1);
            if (!cs_cur_s) begin
              cs_lost_r <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!cs_cur_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // BUSY drops immediately for no-op accesses so they never stall the CPU
  assign BUSY = cs_any_s & (state_r != ST_DONE) & ~((state_r == ST_IDLE) & dec_noop_s);

  assign DOUT           = dout_r;
  assign OP_DATA        = op_data_r;
  assign TO_FLAG        = to_flag_r;
  assign OP_SET_RAM_PTR = ptr_r;
  assign OP_WRITE_RAM   = wram_r;
  assign OP_SELECT_REG  = sel_r;
  assign OP_WRITE_REG   = wreg_r;
  assign OP_READ_RAM_H  = rdh_r;
  assign OP_READ_RAM_L  = rdl_r;

endmodule

// File: tb/tb_gp9001_host_bridge.sv
// Scoreboard bench for gp9001_host_bridge (NCH=2, TIMEOUT=10): stimulus
// pushes expected strobe pulses and CPU completions; monitors pop and compare.
module tb_gp9001_host_bridge;

  localparam int TMO = 10;

  logic        CLK96 = 1'b0;
  logic        RESET96n = 1'b0;
  logic [1:0]  CS = 2'b00;
  logic        RW = 1'b0;
  logic [2:0]  A = 3'd0;
  logic [1:0]  DSn = 2'b11;
  logic [15:0] DIN = 16'h0000;
  logic [15:0] DOUT;
  logic        BUSY;
  logic [1:0]  OP_SET_RAM_PTR, OP_WRITE_RAM, OP_SELECT_REG;
  logic [1:0]  OP_WRITE_REG, OP_READ_RAM_H, OP_READ_RAM_L;
  logic [15:0] OP_DATA;
  logic [1:0]  VDP_ACK = 2'b00;
  logic [31:0] VDP_DOUT = 32'h0;
  logic [1:0]  VBLANK = 2'b00;
  logic [1:0]  TO_FLAG;
  logic        TO_CLR = 1'b0;

  gp9001_host_bridge #(.NCH(2), .DW(16), .TOW(8), .TIMEOUT(TMO)) dut (
    .CLK96(CLK96), .RESET96n(RESET96n), .CS(CS), .RW(RW), .A(A), .DSn(DSn),
    .DIN(DIN), .DOUT(DOUT), .BUSY(BUSY),
    .OP_SET_RAM_PTR(OP_SET_RAM_PTR), .OP_WRITE_RAM(OP_WRITE_RAM),
    .OP_SELECT_REG(OP_SELECT_REG), .OP_WRITE_REG(OP_WRITE_REG),
    .OP_READ_RAM_H(OP_READ_RAM_H), .OP_READ_RAM_L(OP_READ_RAM_L),
    .OP_DATA(OP_DATA), .VDP_ACK(VDP_ACK), .VDP_DOUT(VDP_DOUT),
    .VBLANK(VBLANK), .TO_FLAG(TO_FLAG), .TO_CLR(TO_CLR)
  );

  always #5 CLK96 = ~CLK96;

  // op index order: 0 PTR, 1 WRAM, 2 SEL, 3 WREG, 4 RDH, 5 RDL
  logic [11:0] stb_v;
  assign stb_v = {OP_READ_RAM_L, OP_READ_RAM_H, OP_WRITE_REG,
                  OP_SELECT_REG, OP_WRITE_RAM, OP_SET_RAM_PTR};

  typedef struct {int op; logic [1:0] mask; int width; logic [15:0] data;} stb_t;
  typedef struct {logic chk; logic [15:0] dout; logic busy; int cycles;} cpu_t;
  stb_t stb_q[$];
  cpu_t cpu_q[$];

  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b1;
  logic [1:0] ack_en = 2'b11;
  logic [1:0] ack_hold = 2'b00;
  int   ack_w[2] = '{1, 1};
  logic clr_req = 1'b0;
  logic clr_arm = 1'b0;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_stb(input int op, input logic [1:0] m, input int w, input logic [15:0] d);
    stb_t e;
    e.op = op; e.mask = m; e.width = w; e.data = d;
    stb_q.push_back(e);
  endtask

  task automatic exp_cpu(input logic c, input logic [15:0] d, input logic b, input int cy);
    cpu_t e;
    e.chk = c; e.dout = d; e.busy = b; e.cycles = cy;
    cpu_q.push_back(e);
  endtask

  // One CPU bus cycle: hold CS until BUSY drops, then hold extra cycles
  task automatic bus(input logic [1:0] cs, input logic rw, input logic [3:0] ofs,
                     input logic [1:0] dsn, input logic [15:0] din, input int hold);
    int n;
    @(posedge CLK96); #1;
    CS = cs; RW = rw; A = ofs[3:1]; DSn = dsn; DIN = din;
    n = 0;
    do begin
      @(posedge CLK96); #1;
      n++;
    end while (BUSY && n < 100);
    chk("bus_busy_release", {31'b0, BUSY}, 32'd0);
    @(posedge CLK96); #1;
    repeat (hold) @(posedge CLK96);
    #1;
    CS = 2'b00; DSn = 2'b11;
    @(posedge CLK96); #1;
  endtask

  // Cycle counter of the current CPU access (posedges with CS asserted)
  initial forever begin
    @(posedge CLK96);
    if (CS != 2'b00) cyc++;
    else cyc = 0;
  end

  // Strobe monitor: measures each pulse and compares against the queue
  initial begin : strobe_mon
    int cur_op, w;
    logic [1:0] cur_mask;
    logic [15:0] cur_data;
    logic active;
    stb_t e;
    active = 1'b0; w = 0; cur_op = 0; cur_mask = 2'b00; cur_data = 16'h0;
    forever begin
      @(negedge CLK96);
      if (!mon_en) begin
        active = 1'b0; w = 0;
      end else if (stb_v != 12'h000) begin
        if (!active) begin
          active = 1'b1; w = 0;
          for (int i = 0; i < 6; i++) if (stb_v[i*2 +: 2] != 2'b00) cur_op = i;
          cur_mask = stb_v[cur_op*2 +: 2];
          cur_data = OP_DATA;
          chk("strobe_onehot", $countones(stb_v), 32'd1);
        end
        w++;
      end else if (active) begin
        active = 1'b0;
        if (stb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL strobe_unexpected: op %0d mask %b width %0d, none expected", cur_op, cur_mask, w);
        end else begin
          e = stb_q.pop_front();
          chk("strobe_op", cur_op, e.op);
          chk("strobe_mask", {30'b0, cur_mask}, {30'b0, e.mask});
          chk("strobe_width", w, e.width);
          chk("strobe_op_data", {16'b0, cur_data}, {16'b0, e.data});
        end
      end
    end
  end

  // CPU-side monitor: on first BUSY-low after CS is sampled, check DOUT/latency
  initial begin : cpu_mon
    logic done_f, busy_seen;
    cpu_t e;
    done_f = 1'b0; busy_seen = 1'b0;
    forever begin
      @(negedge CLK96);
      if (!mon_en || CS == 2'b00) begin
        done_f = 1'b0; busy_seen = 1'b0;
      end else begin
        busy_seen = busy_seen | BUSY;
        if (!done_f && cyc >= 1 && !BUSY) begin
          done_f = 1'b1;
          if (cpu_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cpu_unexpected: completion with DOUT %h, none expected", DOUT);
          end else begin
            e = cpu_q.pop_front();
            if (e.chk) chk("cpu_dout", {16'b0, DOUT}, {16'b0, e.dout});
            chk("cpu_busy_seen", {31'b0, busy_seen}, {31'b0, e.busy});
            chk("cpu_cycles", cyc, e.cycles);
          end
        end
      end
    end
  end

  // VDP model: ACK after the strobe has been high ack_w cycles; TO_CLR driver
  initial begin : vdp_model
    int hc[2];
    logic on;
    hc[0] = 0; hc[1] = 0;
    forever begin
      @(negedge CLK96);
      for (int k = 0; k < 2; k++) begin
        on = 1'b0;
        for (int i = 0; i < 6; i++) on = on | stb_v[i*2 + k];
        if (on) hc[k]++;
        else hc[k] = 0;
        VDP_ACK[k] = ack_hold[k] | (ack_en[k] & on & (hc[k] >= ack_w[k]));
      end
      TO_CLR = clr_req | (clr_arm & (hc[0] == TMO + 1));
    end
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time bound expired");
  end

  initial begin
    // reset values
    #12;
    chk("rst_strobes", {20'b0, stb_v}, 32'd0);
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
    chk("rst_dout", {16'b0, DOUT}, 32'd0);
    chk("rst_op_data", {16'b0, OP_DATA}, 32'd0);
    chk("rst_to_flag", {30'b0, TO_FLAG}, 32'd0);
    @(negedge CLK96); RESET96n = 1'b1;
    repeat (2) @(posedge CLK96);

    // SELECT_REG write on ch1, strobe 4 cycles
    ack_w[1] = 4;
    exp_stb(2, 2'b10, 4, 16'h1234); exp_cpu(1'b0, 16'h0, 1'b1, 6);
    bus(2'b10, 1'b0, 4'h8, 2'b00, 16'h1234, 0);

    // READ_RAM_H on ch0
    VDP_DOUT = {16'h1111, 16'hBEEF}; ack_w[0] = 2;
    exp_stb(4, 2'b01, 2, 16'h0000); exp_cpu(1'b1, 16'hBEEF, 1'b1, 4);
    bus(2'b01, 1'b1, 4'h4, 2'b00, 16'h0000, 0);

    // status reads
    VBLANK = 2'b01;
    exp_cpu(1'b1, 16'h0000, 1'b0, 1);
    bus(2'b01, 1'b1, 4'hC, 2'b00, 16'h0000, 0);
    exp_cpu(1'b1, 16'h0001, 1'b0, 1);
    bus(2'b10, 1'b1, 4'hC, 2'b00, 16'h0000, 0);

    // no-op accesses
    exp_cpu(1'b0, 16'h0, 1'b0, 1);
    bus(2'b01, 1'b0, 4'h8, 2'b11, 16'h9999, 0);
    exp_cpu(1'b1, 16'h0000, 1'b0, 1);
    bus(2'b10, 1'b1, 4'h2, 2'b00, 16'h0000, 0);
    exp_cpu(1'b0, 16'h0, 1'b0, 1);
    bus(2'b01, 1'b0, 4'hA, 2'b00, 16'h4444, 0);

    // assorted writes, CS=11 services ch0 only
    ack_w[0] = 1;
    exp_stb(1, 2'b01, 1, 16'hABCD); exp_cpu(1'b0, 16'h0, 1'b1, 3);
    bus(2'b01, 1'b0, 4'h6, 2'b10, 16'hABCD, 0);
    ack_w[0] = 3;
    exp_stb(0, 2'b01, 3, 16'h5555); exp_cpu(1'b0, 16'h0, 1'b1, 5);
    bus(2'b11, 1'b0, 4'h0, 2'b00, 16'h5555, 0);
    ack_w[1] = 2;
    exp_stb(3, 2'b10, 2, 16'h00C3); exp_cpu(1'b0, 16'h0, 1'b1, 4);
    bus(2'b10, 1'b0, 4'hC, 2'b00, 16'h00C3, 0);

    // CS held ~20 cycles with ACK held high: one pulse only
    ack_hold = 2'b01;
    exp_stb(3, 2'b01, 1, 16'h0F0F); exp_cpu(1'b0, 16'h0, 1'b1, 3);
    bus(2'b01, 1'b0, 4'hC, 2'b00, 16'h0F0F, 17);
    ack_hold = 2'b00;

    // watchdog timeout on ch1
    ack_en = 2'b00;
    exp_stb(5, 2'b10, TMO + 1, 16'h0000); exp_cpu(1'b1, 16'hFFFF, 1'b1, TMO + 3);
    bus(2'b10, 1'b1, 4'h6, 2'b00, 16'h0000, 0);
    chk("to_flag_set", {30'b0, TO_FLAG}, 32'd2);
    clr_req = 1'b1;
    @(negedge CLK96); @(negedge CLK96);
    clr_req = 1'b0;
    repeat (2) @(posedge CLK96); #1;
    chk("to_flag_clr", {30'b0, TO_FLAG}, 32'd0);
    exp_stb(5, 2'b10, TMO + 1, 16'h0000); exp_cpu(1'b1, 16'hFFFF, 1'b1, TMO + 3);
    bus(2'b10, 1'b1, 4'h6, 2'b00, 16'h0000, 0);
    // ch0 timeout coinciding with TO_CLR: ch1 cleared, ch0 set
    clr_arm = 1'b1;
    exp_stb(4, 2'b01, TMO + 1, 16'h0000); exp_cpu(1'b1, 16'hFFFF, 1'b1, TMO + 3);
    bus(2'b01, 1'b1, 4'h4, 2'b00, 16'h0000, 0);
    clr_arm = 1'b0;
    chk("to_flag_set_wins", {30'b0, TO_FLAG}, 32'd1);

    // asynchronous reset during WAIT_ACK
    mon_en = 1'b0;
    @(posedge CLK96); #1;
    CS = 2'b10; RW = 1'b0; A = 3'd4; DSn = 2'b00; DIN = 16'h7777;
    repeat (4) @(posedge CLK96);
    #3;
    chk("wait_strobe_on", {20'b0, stb_v}, 32'h020);
    RESET96n = 1'b0; #1;
    chk("arst_strobes", {20'b0, stb_v}, 32'd0);
    chk("arst_dout", {16'b0, DOUT}, 32'd0);
    chk("arst_op_data", {16'b0, OP_DATA}, 32'd0);
    chk("arst_to_flag", {30'b0, TO_FLAG}, 32'd0);
    CS = 2'b00; DSn = 2'b11; #1;
    chk("arst_busy", {31'b0, BUSY}, 32'd0);
    @(negedge CLK96); RESET96n = 1'b1;
    repeat (2) @(posedge CLK96); #1;
    mon_en = 1'b1; ack_en = 2'b11;

    // normal access after reset
    VDP_DOUT = {16'h1357, 16'hBEEF}; ack_w[1] = 2;
    exp_stb(5, 2'b10, 2, 16'h0000); exp_cpu(1'b1, 16'h1357, 1'b1, 4);
    bus(2'b10, 1'b1, 4'h6, 2'b00, 16'h0000, 0);

    repeat (3) @(posedge CLK96);
    chk("stb_queue_empty", stb_q.size(), 32'd0);
    chk("cpu_queue_empty", cpu_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
